// File: rtl/address_generator.sv
// address_generator: raster-scan frame-buffer read address with x/y coordinates and frame strobes
module address_generator #(
  parameter int IMAGE_WIDTH  = 320,
  parameter int IMAGE_HEIGHT = 240,
  parameter int ADDR_BITS    = $clog2(IMAGE_WIDTH*IMAGE_HEIGHT),
  localparam int XW = $clog2(IMAGE_WIDTH),
  localparam int YW = IMAGE_HEIGHT > 1 ? $clog2(IMAGE_HEIGHT) : 1
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 resend,
  output logic [ADDR_BITS-1:0] rdaddress,
  output logic [XW-1:0]        x,
  output logic [YW-1:0]        y,
  output logic                 frame_start,
  output logic                 frame_end
);
  localparam int N = IMAGE_WIDTH*IMAGE_HEIGHT;
  if (IMAGE_WIDTH < 2 || IMAGE_HEIGHT < 1 || ADDR_BITS < $clog2(IMAGE_WIDTH*IMAGE_HEIGHT)) begin : g_bad_params
    $error("address_generator: illegal IMAGE_WIDTH/IMAGE_HEIGHT/ADDR_BITS");
  end
  logic [ADDR_BITS-1:0] addr_q, addr_d;
  logic [XW-1:0]        x_q, x_d;
  logic [YW-1:0]        y_q, y_d;
  logic                 last_x, last;
  // next position: address and coordinates are separate counters, all cleared on resend or frame wrap
  always_comb begin
    last_x = x_q == XW'(IMAGE_WIDTH-1);
    last   = addr_q == ADDR_BITS'(N-1);
    addr_d = (resend || last) ? '0 : addr_q + 1'b1;
    x_d    = (resend || last_x) ? '0 : x_q + 1'b1;
    y_d    = (resend || last) ? '0 : last_x ? y_q + 1'b1 : y_q;
  end
  // state registers; reset takes priority over resend
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      addr_q <= '0;
      x_q    <= '0;
      y_q    <= '0;
    end else begin
      addr_q <= addr_d;
      x_q    <= x_d;
      y_q    <= y_d;
    end
  end
  assign rdaddress   = addr_q;
  assign x           = x_q;
  assign y           = y_q;
  assign frame_start = addr_q == '0;
  assign frame_end   = addr_q == ADDR_BITS'(N-1);
endmodule

// File: tb/tb_address_generator.sv
// tb_address_generator: directed stimulus with a queued scoreboard checked by an independent monitor
module tb_address_generator;
  localparam int W = 320;
  localparam int H = 240;
  localparam int N = W*H;
  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        resend = 1'b0;
  logic [16:0] rdaddress;
  logic [8:0]  x;
  logic [7:0]  y;
  logic        frame_start, frame_end;
  int total = 0;
  int bad = 0;
  typedef struct {
    bit    chk;
    int    a;
    int    ex;
    int    ey;
    string nm;
  } exp_t;
  exp_t q[$];
  address_generator dut (
    .clk(clk), .reset_n(reset_n), .resend(resend), .rdaddress(rdaddress),
    .x(x), .y(y), .frame_start(frame_start), .frame_end(frame_end)
  );
  always #5 clk = ~clk;
  // drive one edge's inputs and queue what the outputs must be after that edge
  task automatic cyc(input bit rn, input bit rs, input bit chk, input int a, input int ex, input int ey, input string nm);
    @(negedge clk);
    reset_n = rn;
    resend = rs;
    q.push_back('{chk, a, ex, ey, nm});
  endtask
  task automatic idle(input bit rn, input bit rs);
    cyc(rn, rs, 1'b0, 0, 0, 0, "");
  endtask
  // monitor: one scoreboard entry per edge; directed values where given, structural invariants always
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() != 0) begin
        e = q.pop_front();
        if (e.chk) begin
          total++;
          if (int'(rdaddress) != e.a || int'(x) != e.ex || int'(y) != e.ey ||
              frame_start != (e.a == 0) || frame_end != (e.a == N-1)) begin
            bad++;
            $display("FAIL %s: got addr=%0d x=%0d y=%0d fs=%0b fe=%0b, want addr=%0d x=%0d y=%0d fs=%0b fe=%0b",
                     e.nm, rdaddress, x, y, frame_start, frame_end, e.a, e.ex, e.ey, e.a == 0, e.a == N-1);
          end
        end
        total++;
        if (int'(rdaddress) != int'(y)*W + int'(x) || int'(x) >= W || int'(y) >= H ||
            frame_start != (rdaddress == 0) || frame_end != (int'(rdaddress) == N-1) ||
            (frame_start && frame_end)) begin
          bad++;
          $display("FAIL invariant: got addr=%0d x=%0d y=%0d fs=%0b fe=%0b, want addr==y*%0d+x in range with matching strobes",
                   rdaddress, x, y, frame_start, frame_end, W);
        end
      end
    end
  end
  initial begin
    int wait_cnt;
    for (int i = 0; i < 3; i++) cyc(0, 0, 1, 0, 0, 0, "reset");
    for (int k = 1; k <= N + 1; k++) begin
      if (k == 1) cyc(1, 0, 1, 1, 1, 0, "run_first");
      else if (k == 319) cyc(1, 0, 1, 319, 319, 0, "row0_end");
      else if (k == 320) cyc(1, 0, 1, 320, 0, 1, "row1_start");
      else if (k == 500) cyc(1, 0, 1, 500, 180, 1, "run_500");
      else if (k == 76479) cyc(1, 0, 1, 76479, 319, 238, "row238_end");
      else if (k == 76480) cyc(1, 0, 1, 76480, 0, 239, "row239_start");
      else if (k == 76799) cyc(1, 0, 1, 76799, 319, 239, "frame_end");
      else if (k == 76800) cyc(1, 0, 1, 0, 0, 0, "wrap");
      else if (k == 76801) cyc(1, 0, 1, 1, 1, 0, "after_wrap");
      else idle(1, 0);
    end
    for (int k = 2; k < 1234; k++) idle(1, 0);
    cyc(1, 0, 1, 1234, 274, 3, "at_1234");
    cyc(1, 1, 1, 0, 0, 0, "resend_pulse");
    cyc(1, 0, 1, 1, 1, 0, "resend_resume1");
    cyc(1, 0, 1, 2, 2, 0, "resend_resume2");
    for (int i = 0; i < 4; i++) cyc(1, 1, 1, 0, 0, 0, "resend_held");
    cyc(1, 0, 1, 1, 1, 0, "held_resume1");
    cyc(1, 0, 1, 2, 2, 0, "held_resume2");
    for (int k = 3; k < 100; k++) idle(1, 0);
    cyc(1, 0, 1, 100, 100, 0, "at_100");
    cyc(0, 1, 1, 0, 0, 0, "reset_and_resend");
    cyc(1, 1, 1, 0, 0, 0, "resend_after_reset1");
    cyc(1, 1, 1, 0, 0, 0, "resend_after_reset2");
    cyc(1, 0, 1, 1, 1, 0, "rr_resume1");
    cyc(1, 0, 1, 2, 2, 0, "rr_resume2");
    wait_cnt = 0;
    while (q.size() != 0 && wait_cnt < 10) begin
      @(posedge clk);
      wait_cnt++;
    end
    #2;
    if (q.size() != 0) begin
      total++;
      bad++;
      $display("FAIL drain: got %0d entries pending, want 0", q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
